// File: rtl/coin_return_dispenser_pkg.sv
// Shared vending-machine definitions: coin denominations, default widths and
// the dispenser state encoding.
package coin_return_dispenser_pkg;

  localparam int unsigned kNumCoinsDefault  = 32'd3;
  localparam int unsigned kTotalBitsDefault = 32'd31;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DISPENSE = 2'd1,
    ST_DONE     = 2'd2
  } state_e;

  // Face value of the coin on one-hot bit idx; unknown bits are worth nothing.
  function automatic logic [31:0] coin_value(input int unsigned idx);
    logic [31:0] value;
    case (idx)
      32'd0:   value = 32'd100;
      32'd1:   value = 32'd500;
      32'd2:   value = 32'd1000;
      default: value = 32'd0;
    endcase
    return value;
  endfunction

endpackage

// File: rtl/coin_return_dispenser_if.sv
// Request / coin-chute handshake bundle between the vending controller
// (master) and the coin return dispenser (slave).
interface coin_return_dispenser_if #(
  parameter int unsigned kNumCoins  = 32'd3,
  parameter int unsigned kTotalBits = 32'd31
);
  logic                  i_start;
  logic [kTotalBits-1:0] i_total;
  logic                  i_ready;
  logic [kNumCoins-1:0]  o_return_coin;
  logic                  o_coin_valid;
  logic                  o_busy;
  logic                  o_done;
  logic [kTotalBits-1:0] o_remaining;
  logic                  o_residue;

  modport slave (
    input  i_start, i_total, i_ready,
    output o_return_coin, o_coin_valid, o_busy, o_done, o_remaining, o_residue
  );

  modport master (
    output i_start, i_total, i_ready,
    input  o_return_coin, o_coin_valid, o_busy, o_done, o_remaining, o_residue
  );
endinterface

// File: rtl/coin_return_dispenser_coin_select.sv
// Greedy coin picker: the largest denomination not exceeding the amount owed.
// Purely combinational.
module coin_select
  import coin_return_dispenser_pkg::*;
#(
  parameter int unsigned kNumCoins  = kNumCoinsDefault,
  parameter int unsigned kTotalBits = kTotalBitsDefault
) (
  input  logic [kTotalBits-1:0] remaining_i,
  output logic [kNumCoins-1:0]  coin_o,
  output logic [kTotalBits-1:0] value_o,
  output logic                  valid_o
);

  // Scan from the largest denomination down; the first that fits wins.
  always_comb begin
    coin_o  = '0;
    value_o = '0;
    valid_o = 1'b0;
    for (int i = int'(kNumCoins) - 1; i >= 0; i--) begin
      if (!valid_o && (coin_value(int'(i)) != 32'd0) &&
          (remaining_i >= kTotalBits'(coin_value(int'(i))))) begin
        coin_o[i] = 1'b1;
        value_o   = kTotalBits'(coin_value(int'(i)));
        valid_o   = 1'b1;
      end else begin
        valid_o = valid_o;
      end
    end
  end

endmodule

// File: rtl/coin_return_dispenser.sv
// Coin return dispenser: latches the amount owed and pays it out one coin per
// accepted chute handshake, then pulses done and flags any sub-100 residue.
module coin_return_dispenser
  import coin_return_dispenser_pkg::*;
#(
  parameter int unsigned kNumCoins  = kNumCoinsDefault,
  parameter int unsigned kTotalBits = kTotalBitsDefault
) (
  input  logic                    clk,
  input  logic                    reset_n,
  coin_return_dispenser_if.slave  bus
);

  state_e                state_q;
  logic [kTotalBits-1:0] remaining_q;
  logic                  residue_q;

  logic [kNumCoins-1:0]  sel_coin_s;
  logic [kTotalBits-1:0] sel_value_s;
  logic                  sel_valid_s;

  coin_select #(
    .kNumCoins  (kNumCoins),
    .kTotalBits (kTotalBits)
  ) u_coin_select (
    .remaining_i (remaining_q),
    .coin_o      (sel_coin_s),
    .value_o     (sel_value_s),
    .valid_o     (sel_valid_s)
  );

  // Return FSM with the amount-owed and residue registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      residue_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.i_start) begin
            remaining_q <= bus.i_total;
            residue_q   <= 1'b0;
            state_q     <= ST_DISPENSE;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_DISPENSE: begin
          // Nothing left that a coin can cover: finish without waiting on the chute.
          if (!sel_valid_s) begin
            residue_q <= (remaining_q != '0);
            state_q   <= ST_DONE;
          end else if (bus.i_ready) begin
            remaining_q <= remaining_q - sel_value_s;
          end else begin
            state_q <= ST_DISPENSE;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Outputs decode straight from registered state so reset clears them at once.
  always_comb begin
    bus.o_coin_valid  = 1'b0;
    bus.o_return_coin = '0;
    if ((state_q == ST_DISPENSE) && sel_valid_s) begin
      bus.o_coin_valid  = 1'b1;
      bus.o_return_coin = sel_coin_s;
    end else begin
      bus.o_coin_valid  = 1'b0;
      bus.o_return_coin = '0;
    end
  end

  assign bus.o_busy      = (state_q != ST_IDLE);
  assign bus.o_done      = (state_q == ST_DONE);
  assign bus.o_remaining = remaining_q;
  assign bus.o_residue   = residue_q;

endmodule

// File: tb/tb_coin_return_dispenser.sv
// Directed bench for coin_return_dispenser with a payout-list reference model
// and hand-computed per-cycle expectations.
module tb_coin_return_dispenser;

  logic clk;
  logic reset_n;
  int   n_chk;
  int   n_err;

  coin_return_dispenser_if #(.kNumCoins(3), .kTotalBits(31)) bus ();

  coin_return_dispenser #(.kNumCoins(3), .kTotalBits(31)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (act !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Payout plan for a total: how many of each coin, in greedy order.
  function automatic int unsigned n_coins(input int unsigned t);
    return t / 1000 + (t % 1000) / 500 + (t % 500) / 100;
  endfunction

  function automatic int unsigned coin_at(input int unsigned t, input int unsigned idx);
    int unsigned a;
    int unsigned b;
    a = t / 1000;
    b = (t % 1000) / 500;
    if (idx < a) return 1000;
    else if (idx < a + b) return 500;
    else return 100;
  endfunction

  function automatic int unsigned paid(input int unsigned t, input int unsigned idx);
    int unsigned s;
    s = 0;
    for (int unsigned k = 0; k < idx; k++) s = s + coin_at(t, k);
    return s;
  endfunction

  function automatic logic [31:0] onehot(input int unsigned v);
    if (v == 1000) return 32'd4;
    else if (v == 500) return 32'd2;
    else return 32'd1;
  endfunction

  // Model: phase 0 idle, 1 paying out, 2 done.
  int unsigned m_phase;
  int unsigned m_total;
  int unsigned m_idx;
  bit          m_residue;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_phase   <= 0;
      m_total   <= 0;
      m_idx     <= 0;
      m_residue <= 1'b0;
    end else if (m_phase == 0) begin
      if (bus.i_start) begin
        m_total   <= bus.i_total;
        m_idx     <= 0;
        m_residue <= 1'b0;
        m_phase   <= 1;
      end
    end else if (m_phase == 1) begin
      if (m_idx < n_coins(m_total)) begin
        if (bus.i_ready) m_idx <= m_idx + 1;
      end else begin
        m_residue <= ((m_total % 100) != 0);
        m_phase   <= 2;
      end
    end else begin
      m_phase <= 0;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("m_busy", 32'(bus.o_busy), 32'(m_phase != 0));
    chk("m_done", 32'(bus.o_done), 32'(m_phase == 2));
    chk("m_valid", 32'(bus.o_coin_valid), 32'((m_phase == 1) && (m_idx < n_coins(m_total))));
    chk("m_coin", 32'(bus.o_return_coin),
        ((m_phase == 1) && (m_idx < n_coins(m_total))) ? onehot(coin_at(m_total, m_idx)) : 32'd0);
    chk("m_remaining", 32'(bus.o_remaining), m_total - paid(m_total, m_idx));
    chk("m_residue", 32'(bus.o_residue), 32'(m_residue));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Request a return; leaves the bench 1 ns into the first offer cycle.
  task automatic start_req(input logic [30:0] t);
    step();
    bus.i_start = 1'b1;
    bus.i_total = t;
    step();
    bus.i_start = 1'b0;
    bus.i_total = 31'd7777;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (bus.o_busy && k < 40) begin
      step();
      k++;
    end
    chk("idle_timeout", 32'(bus.o_busy), 32'd0);
  endtask

  task automatic chk_coin(input string name, input logic [31:0] coin, input logic [31:0] rem);
    chk({name, "_coin"}, 32'(bus.o_return_coin), coin);
    chk({name, "_valid"}, 32'(bus.o_coin_valid), 32'(coin != 32'd0));
    chk({name, "_rem"}, 32'(bus.o_remaining), rem);
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    reset_n = 1'b0;
    bus.i_start = 1'b0;
    bus.i_total = '0;
    bus.i_ready = 1'b1;
    step();
    chk("rst_busy", 32'(bus.o_busy), 32'd0);
    chk("rst_valid", 32'(bus.o_coin_valid), 32'd0);
    chk("rst_rem", 32'(bus.o_remaining), 32'd0);
    step();
    reset_n = 1'b1;

    // 1700: 1000, 500, 100, 100 back to back
    start_req(31'd1700);
    chk_coin("t1700_c0", 32'd4, 32'd1700); step();
    chk_coin("t1700_c1", 32'd2, 32'd700);  step();
    chk_coin("t1700_c2", 32'd1, 32'd200);  step();
    chk_coin("t1700_c3", 32'd1, 32'd100);  step();
    chk_coin("t1700_end", 32'd0, 32'd0);   step();
    chk("t1700_done", 32'(bus.o_done), 32'd1);
    chk("t1700_res", 32'(bus.o_residue), 32'd0);
    step();
    chk("t1700_done_once", 32'(bus.o_done), 32'd0);
    wait_idle();

    // 0: no coin, done two cycles after the start edge
    start_req(31'd0);
    chk_coin("t0_c", 32'd0, 32'd0);
    chk("t0_busy", 32'(bus.o_busy), 32'd1);
    step();
    chk("t0_done", 32'(bus.o_done), 32'd1);
    chk("t0_res", 32'(bus.o_residue), 32'd0);
    wait_idle();

    // 600 with the chute stalled for three cycles on the 500 offer
    start_req(31'd600);
    for (int k = 0; k < 3; k++) begin
      bus.i_ready = 1'b0;
      chk_coin("t600_stall", 32'd2, 32'd600);
      step();
    end
    bus.i_ready = 1'b1;
    chk_coin("t600_c0", 32'd2, 32'd600); step();
    chk_coin("t600_c1", 32'd1, 32'd100); step();
    chk_coin("t600_end", 32'd0, 32'd0);
    wait_idle();

    // 150: one coin, 50 left over flagged as residue until the next start
    start_req(31'd150);
    chk_coin("t150_c0", 32'd1, 32'd150); step();
    chk_coin("t150_end", 32'd0, 32'd50); step();
    chk("t150_done", 32'(bus.o_done), 32'd1);
    chk("t150_res", 32'(bus.o_residue), 32'd1);
    wait_idle();
    step(); step();
    chk("t150_res_hold", 32'(bus.o_residue), 32'd1);
    chk("t150_rem_hold", 32'(bus.o_remaining), 32'd50);
    start_req(31'd0);
    chk("t150_res_clr", 32'(bus.o_residue), 32'd0);
    wait_idle();

    // 2000 abandoned by reset after the first transfer
    start_req(31'd2000);
    chk_coin("t2000_c0", 32'd4, 32'd2000); step();
    chk_coin("t2000_c1", 32'd4, 32'd1000);
    reset_n = 1'b0;
    #1;
    chk_coin("t2000_rst", 32'd0, 32'd0);
    chk("t2000_rst_busy", 32'(bus.o_busy), 32'd0);
    step();
    reset_n = 1'b1;
    start_req(31'd100);
    chk_coin("t100_c0", 32'd1, 32'd100); step();
    chk_coin("t100_end", 32'd0, 32'd0);
    wait_idle();

    // 1100 with a stray start of 500 while busy
    start_req(31'd1100);
    chk_coin("t1100_c0", 32'd4, 32'd1100);
    bus.i_start = 1'b1;
    bus.i_total = 31'd500;
    step();
    bus.i_start = 1'b0;
    chk_coin("t1100_c1", 32'd1, 32'd100); step();
    chk_coin("t1100_end", 32'd0, 32'd0);
    wait_idle();
    step();
    chk("t1100_no_requeue", 32'(bus.o_busy), 32'd0);
    chk("t1100_rem", 32'(bus.o_remaining), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/coin_return_dispenser.md
COIN_RETURN_DISPENSER -- requirements
Module: coin_return_dispenser

Interface
REQ-001 SHALL have parameter kNumCoins, default 3, number of coin denominations.
REQ-002 SHALL have parameter kTotalBits, default 31, width of the money total.
REQ-003 SHALL have coin values 100, 500 and 1000 for bits 0, 1 and 2, taken from the shared definitions.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 reset_n  input  1  reset, asynchronous and active-low.
REQ-006 i_start  input  1  return request, e.g. wait time expired or the return button.
REQ-007 i_total  input  kTotalBits  amount owed to the customer, sampled on an accepted i_start.
REQ-008 i_ready  input  1  coin chute can accept a coin this cycle.
REQ-009 o_return_coin  output  kNumCoins  one-hot coin offered this cycle; all zeros when o_coin_valid is 0.
REQ-010 o_coin_valid  output  1  a coin is offered; a transfer occurs when o_coin_valid and i_ready are both 1 at a rising edge.
REQ-011 o_busy  output  1  high in every state except IDLE.
REQ-012 o_done  output  1  single-cycle pulse when a return completes.
REQ-013 o_remaining  output  kTotalBits  amount still owed.
REQ-014 o_residue  output  1  set at completion when o_remaining is nonzero (amount not a multiple of 100).

Function
REQ-015 SHALL implement an FSM with three states: IDLE, DISPENSE, DONE.
REQ-016 IDLE: on a rising edge with i_start=1, latch i_total into o_remaining and move to DISPENSE.
REQ-017 First coin timing: with the request accepted at edge N, the first coin SHALL be offered in the cycle after edge N.
REQ-018 DISPENSE coin selection (greedy, from current o_remaining): 1000 if remaining >= 1000; else 500 if >= 500; else 100 if >= 100.
REQ-019 DISPENSE: o_coin_valid = (o_remaining >= 100), decoded combinationally from current state.
REQ-020 On a transfer, o_remaining SHALL decrease by the offered coin value at that edge; the next coin is re-selected from the new value.
REQ-021 Stall: while i_ready=0, o_return_coin and o_remaining SHALL hold stable, with no transfer and no decrement.
REQ-022 DISPENSE with o_remaining < 100: move to DONE at the next edge without requiring i_ready.
REQ-023 DONE: hold o_done=1 for exactly one cycle.
REQ-024 DONE: o_residue = (o_remaining != 0).
REQ-025 DONE: move to IDLE at the next edge.
REQ-026 o_residue SHALL hold its value until the next accepted i_start, which clears it.
REQ-027 i_start SHALL be ignored while o_busy=1; no re-latch and no queuing.
REQ-028 i_total = 0 SHALL give IDLE -> DISPENSE -> DONE with no coin and o_residue=0.
REQ-029 Subtraction SHALL never underflow, since a coin is only offered when remaining >= its value.
REQ-030 Arithmetic SHALL be kTotalBits wide with no truncation.
REQ-031 i_total changing after acceptance SHALL have no effect.

Reset
REQ-032 On reset_n low, the block SHALL asynchronously enter IDLE with o_remaining=0, o_residue=0, o_done=0, o_coin_valid=0, o_return_coin=0 and o_busy=0.
REQ-033 Reset mid-DISPENSE SHALL abandon the return with no further coin offered; remaining coins are not remembered.
REQ-034 After release, the first active edge SHALL behave as IDLE.

Structure
REQ-035 Coin values, kNumCoins, kTotalBits and the state encodings SHALL live in the shared vending-machine definitions file.
REQ-036 Greedy coin selection SHALL be a sub-module coin_select (input remaining; outputs one-hot coin, coin value, valid), purely combinational.
REQ-037 The FSM, remaining register and handshake SHALL stay in coin_return_dispenser.

Verification
REQ-038 i_total=1700, i_ready=1: coins 1000, 500, 100, 100 on consecutive cycles, then o_done pulse, o_remaining=0, o_residue=0.
REQ-039 i_total=0: no o_coin_valid; o_done pulses 2 cycles after the start edge; o_residue=0.
REQ-040 i_total=600, i_ready low 3 cycles during the 500 offer: 500 held stable 3 cycles with o_remaining=600, then coins 500, 100, then done.
REQ-041 i_total=150: one 100 coin, then done with o_remaining=50 and o_residue=1, held until the next start.
REQ-042 i_total=2000, reset_n low after the first 1000 transfer: outputs zero immediately, IDLE; a new start with 100 gives a single 100 coin.
REQ-043 i_start pulsed with i_total=500 while dispensing 1100: ignored; exactly 1000, 100 returned, then done.
